// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: evaluates ARM conditions against the committed CPSR flags,
// commits flag updates, and registers one qualified register-file write per cycle.
module alu_writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall,
  input  logic [3:0]  cond,
  input  logic        set_flags,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  input  logic        alu_wb,
  input  logic [3:0]  rd,
  input  logic        cpsr_we,
  input  logic [3:0]  cpsr_wdata,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        pc_write,
  output logic [3:0]  cpsr,
  output logic        cond_pass,
  output logic [15:0] exec_count,
  output logic [15:0] skip_count
);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  logic flag_z, flag_c, flag_n, flag_v;
  logic cond_true;
  logic accept;
  logic pass;
  logic do_write;

  assign flag_z = cpsr[0];
  assign flag_c = cpsr[1];
  assign flag_n = cpsr[2];
  assign flag_v = cpsr[3];

  // NOTE: the default assignment ahead of the case keeps this purely combinational
  // for every cond value, so no latch is inferred.
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_true = flag_z;
      COND_NE: cond_true = ~flag_z;
      COND_CS: cond_true = flag_c;
      COND_CC: cond_true = ~flag_c;
      COND_MI: cond_true = flag_n;
      COND_PL: cond_true = ~flag_n;
      COND_VS: cond_true = flag_v;
      COND_VC: cond_true = ~flag_v;
      COND_HI: cond_true = flag_c & ~flag_z;
      COND_LS: cond_true = ~flag_c | flag_z;
      COND_GE: cond_true = (flag_n == flag_v);
      COND_LT: cond_true = (flag_n != flag_v);
      COND_GT: cond_true = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_true = flag_z | (flag_n != flag_v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign accept   = valid_in & ~stall;
  assign pass     = accept & cond_true;
  assign do_write = pass & alu_wb;

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; back-to-back instructions then see the flags committed by
  // their predecessor without any bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en      <= 1'b0;
      wb_addr    <= 4'h0;
      wb_data    <= 32'h0;
      pc_write   <= 1'b0;
      cpsr       <= 4'b0000;
      cond_pass  <= 1'b0;
      exec_count <= 16'h0;
      skip_count <= 16'h0;
    end else begin
      wb_en    <= do_write;
      pc_write <= do_write & (rd == 4'hF);
      if (do_write) begin
        wb_addr <= rd;
        wb_data <= alu_result;
      end

      // Direct writes win over an ALU commit in the same cycle, even under stall.
      if (cpsr_we)
        cpsr <= cpsr_wdata;
      else if (pass & set_flags)
        cpsr <= alu_flags;

      if (accept)
        cond_pass <= pass;

      if (pass && exec_count != 16'hFFFF)
        exec_count <= exec_count + 16'd1;
      if (accept && !cond_true && skip_count != 16'hFFFF)
        skip_count <= skip_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus random
// traffic, all compared against a flag/counter reference model held in the bench.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        stall;
  logic [3:0]  cond;
  logic        set_flags;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        alu_wb;
  logic [3:0]  rd;
  logic        cpsr_we;
  logic [3:0]  cpsr_wdata;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_write;
  logic [3:0]  cpsr;
  logic        cond_pass;
  logic [15:0] exec_count;
  logic [15:0] skip_count;

  alu_writeback_stage dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .stall      (stall),
    .cond       (cond),
    .set_flags  (set_flags),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .alu_wb     (alu_wb),
    .rd         (rd),
    .cpsr_we    (cpsr_we),
    .cpsr_wdata (cpsr_wdata),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .pc_write   (pc_write),
    .cpsr       (cpsr),
    .cond_pass  (cond_pass),
    .exec_count (exec_count),
    .skip_count (skip_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic        m_wb_en, m_pc_write, m_cond_pass;
  logic [3:0]  m_wb_addr, m_cpsr;
  logic [31:0] m_wb_data;
  int          m_exec, m_skip;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Conditions come in true/inverted pairs; the low bit inverts the base test.
  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic z, c, n, v, base;
    z = f[0]; c = f[1]; n = f[2]; v = f[3];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cc == 4'hF) return 1'b0;
    return cc[0] ? !base : base;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".wb_en"},      wb_en,      m_wb_en);
    check({tag, ".wb_addr"},    wb_addr,    m_wb_addr);
    check({tag, ".wb_data"},    wb_data,    m_wb_data);
    check({tag, ".pc_write"},   pc_write,   m_pc_write);
    check({tag, ".cpsr"},       cpsr,       m_cpsr);
    check({tag, ".cond_pass"},  cond_pass,  m_cond_pass);
    check({tag, ".exec_count"}, exec_count, m_exec[15:0]);
    check({tag, ".skip_count"}, skip_count, m_skip[15:0]);
  endtask

  // One clock of stimulus; model predicts the post-edge outputs from pre-edge state.
  task automatic step(input string tag, input logic v, input logic s, input logic [3:0] c,
                      input logic sf, input logic [31:0] res, input logic [3:0] fl,
                      input logic wb, input logic [3:0] r, input logic we,
                      input logic [3:0] wd, input bit full_check = 1'b1);
    logic acc, ct, ps;
    reset = 1'b0; valid_in = v; stall = s; cond = c; set_flags = sf;
    alu_result = res; alu_flags = fl; alu_wb = wb; rd = r; cpsr_we = we; cpsr_wdata = wd;
    acc = v && !s;
    ct  = cond_ok(c, m_cpsr);
    ps  = acc && ct;
    m_wb_en    = ps && wb;
    m_pc_write = ps && wb && (r == 4'hF);
    if (ps && wb) begin
      m_wb_addr = r;
      m_wb_data = res;
    end
    if (we) m_cpsr = wd;
    else if (ps && sf) m_cpsr = fl;
    if (acc) m_cond_pass = ps;
    if (ps && m_exec < 65535) m_exec++;
    if (acc && !ct && m_skip < 65535) m_skip++;
    @(posedge clk);
    #1;
    if (full_check) check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; valid_in = 1'b1; stall = 1'b0; cond = 4'hE; set_flags = 1'b1;
    alu_result = $urandom; alu_flags = 4'hF; alu_wb = 1'b1; rd = 4'hF;
    cpsr_we = 1'b1; cpsr_wdata = 4'hA;
    m_wb_en = 0; m_pc_write = 0; m_cond_pass = 0; m_wb_addr = 0; m_cpsr = 0;
    m_wb_data = 0; m_exec = 0; m_skip = 0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    do_reset("reset");

    // AL ADD r3 = 10, S set with flags 0000
    step("add", 1, 0, 4'hE, 1, 32'd10, 4'b0000, 1, 4'd3, 0, 4'h0);
    check("add_wb_en", wb_en, 1);
    check("add_wb_addr", wb_addr, 3);
    check("add_wb_data", wb_data, 10);
    check("add_exec", exec_count, 1);

    // CMP sets Z, then EQ MOV r2 passes, NE MOV r4 is skipped
    step("cmp", 1, 0, 4'hE, 1, 32'd0, 4'b0001, 0, 4'd0, 0, 4'h0);
    check("cmp_no_wb", wb_en, 0);
    check("cmp_cpsr", cpsr, 4'b0001);
    step("eq_mov", 1, 0, 4'h0, 0, 32'd5, 4'b0000, 1, 4'd2, 0, 4'h0);
    check("eq_wb", {wb_en, wb_addr}, {1'b1, 4'd2});
    check("eq_data", wb_data, 5);
    step("ne_mov", 1, 0, 4'h1, 0, 32'd7, 4'b0000, 1, 4'd4, 0, 4'h0);
    check("ne_no_wb", wb_en, 0);
    check("ne_skip", skip_count, 1);

    // Signed conditions with V=1, N=0
    step("msr_v", 0, 0, 4'hE, 0, 32'd0, 4'h0, 0, 4'd0, 1, 4'b1000);
    step("ge", 1, 0, 4'hA, 0, 32'd1, 4'h0, 1, 4'd1, 0, 4'h0);
    check("ge_pass", cond_pass, 0);
    step("lt", 1, 0, 4'hB, 0, 32'd2, 4'h0, 1, 4'd1, 0, 4'h0);
    check("lt_pass", cond_pass, 1);
    step("gt", 1, 0, 4'hC, 0, 32'd3, 4'h0, 1, 4'd1, 0, 4'h0);
    check("gt_pass", cond_pass, 0);
    step("le", 1, 0, 4'hD, 0, 32'd4, 4'h0, 1, 4'd1, 0, 4'h0);
    check("le_pass", cond_pass, 1);
    step("msr_n", 0, 0, 4'hE, 0, 32'd0, 4'h0, 0, 4'd0, 1, 4'b0100);
    step("mi", 1, 0, 4'h4, 0, 32'd8, 4'h0, 1, 4'd5, 0, 4'h0);
    check("mi_pass", cond_pass, 1);
    step("pl", 1, 0, 4'h5, 0, 32'd9, 4'h0, 1, 4'd5, 0, 4'h0);
    check("pl_pass", cond_pass, 0);

    // Direct write collides with an executing S instruction; NV never writes
    step("collide", 1, 0, 4'hE, 1, 32'd11, 4'b0101, 1, 4'd6, 1, 4'b0010);
    check("collide_cpsr", cpsr, 4'b0010);
    step("nv", 1, 0, 4'hF, 1, 32'd12, 4'b1111, 1, 4'd7, 0, 4'h0);
    check("nv_no_wb", wb_en, 0);

    // r15 write pulses pc_write for one cycle; stall freezes everything
    step("pc_wr", 1, 0, 4'hE, 0, 32'h100, 4'h0, 1, 4'hF, 0, 4'h0);
    check("pc_pulse", pc_write, 1);
    step("after_pc", 1, 0, 4'hE, 0, 32'h104, 4'h0, 1, 4'd1, 0, 4'h0);
    check("pc_drop", pc_write, 0);
    step("stall", 1, 1, 4'hE, 1, 32'h55, 4'hF, 1, 4'hF, 0, 4'h0);
    check("stall_wb", {wb_en, pc_write}, 2'b00);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 4'($urandom),
           1'($urandom), $urandom, 4'($urandom), 1'($urandom), 4'($urandom),
           $urandom_range(0, 7) == 0, 4'($urandom));

    // Saturation: exec_count pins at FFFF
    for (int i = 0; i < 65540; i++)
      step("sat", 1, 0, 4'hE, 0, i, 4'h0, 1'(i), 4'($urandom), 0, 4'h0, (i % 4096) == 0);
    check_all("sat_end");
    check("exec_sat", exec_count, 16'hFFFF);

    // Reset with a valid instruction and direct flag write in flight
    do_reset("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Execute/writeback stage behind the ALU. Holds the architectural CPSR flags (Z, C, N, V), evaluates each instruction's 4-bit ARM condition against the committed flags, and commits ALU flags and ALU results. Qualifies the ALU's writeback request with the condition outcome and presents one registered write per cycle to the register file. Also keeps saturating executed/skipped instruction counters for debug.

## Interface
- No parameters; all widths fixed (32-bit data, 4-bit register index, 4-bit flags).
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  instruction present this cycle.
- stall  in  1  hold stage; input ignored, bubble emitted.
- cond  in  4  ARM condition field.
- set_flags  in  1  S bit; commit alu_flags if executed.
- alu_result  in  32  ALU result.
- alu_flags  in  4  ALU flags: [0]=Z, [1]=C, [2]=N, [3]=V.
- alu_wb  in  1  ALU writeback request (0 for TST/TEQ/CMP/CMN/no-op).
- rd  in  4  destination register index.
- cpsr_we  in  1  direct flag write (MSR-style).
- cpsr_wdata  in  4  direct flag value, same bit order as alu_flags.
- wb_en  out  1  register-file write enable.
- wb_addr  out  4  register-file write index.
- wb_data  out  32  register-file write data.
- pc_write  out  1  pulse: executed write to r15.
- cpsr  out  4  committed flags, same bit order.
- cond_pass  out  1  registered condition outcome of the last accepted instruction.
- exec_count  out  16  executed-instruction count, saturating.
- skip_count  out  16  condition-failed instruction count, saturating.

## Operation
- accept = valid_in & ~stall.
- Conditions use committed cpsr; bit names Z=cpsr[0], C=cpsr[1], N=cpsr[2], V=cpsr[3].
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111 NV: 0, never executes.
- pass = accept & cond_true.
- Flag update priority:
  - cpsr_we=1: cpsr <= cpsr_wdata. Applies regardless of stall/valid, and wins over any ALU update in the same cycle.
  - else pass & set_flags: cpsr <= alu_flags.
  - else cpsr holds.
- Writeback (registered each cycle):
  - wb_en <= pass & alu_wb.
  - wb_addr <= rd and wb_data <= alu_result when pass & alu_wb; otherwise both hold their previous value.
  - pc_write <= pass & alu_wb & (rd==4'hF).
- cond_pass <= pass when accept; holds otherwise.
- Counters, both saturating at 16'hFFFF (no wrap):
  - exec_count +1 on pass.
  - skip_count +1 on accept & ~cond_true.
- Stall: no state change except cpsr_we. wb_en and pc_write are 0 in the following cycle.
- No internal state machine beyond the registers above; each accepted instruction is independent.

## Timing
- Reset values: wb_en=0, wb_addr=0, wb_data=0, pc_write=0, cpsr=4'b0000, cond_pass=0, exec_count=0, skip_count=0.
- Reset overrides every other input in the same edge, including cpsr_we.
- Latency: 1 cycle from input edge to wb_*, pc_write, cpsr, and counter updates.
- Back-to-back: instruction k+1 sees flags set by instruction k (cpsr updates at the same edge that registers k). No bypass needed, no bubble required.
- Reset asserted mid-stream: the in-flight instruction is discarded, with no write and no flag commit.
- Throughput: one instruction per cycle while stall=0.

## Test plan
- Reset, then AL ADD: cond=1110, set_flags=1, alu_result=10, alu_flags=0000, alu_wb=1, rd=3. Next cycle: wb_en=1, wb_addr=3, wb_data=10, cpsr=0000, exec_count=1.
- Flag dependency: CMP with alu_flags=0001 (Z), alu_wb=0, set_flags=1; next cycle EQ MOV rd=2, data=5; then NE MOV rd=4. Required: no write for CMP; r2 written with 5; NE skipped with wb_en=0; skip_count=1.
- Signed conditions: cpsr_we with cpsr_wdata=1000 (V=1, N=0), then GE, LT, GT, LE instructions. Required pass pattern 0,1,0,1; after the next cpsr_we with 0100 (N=1), MI passes and PL fails.
- Collision and NV: same cycle cpsr_we=1 with 0010 and an executing S-instruction with alu_flags=0101. Required: cpsr=0010. An NV instruction with alu_wb=1 gives wb_en=0.
- r15 and stall: executed write with rd=15 gives pc_write=1 for exactly one cycle. stall=1 with valid_in=1 gives wb_en=0, counters unchanged, cpsr unchanged.
- Saturation and mid-reset: 65540 executed AL instructions leave exec_count=FFFF. Then reset asserted with valid_in=1 gives all outputs at reset values the next cycle.
